// File: rtl/capture_ctrl.sv
// Capture-side controller for the 3-channel trace RAM.
// Paces circular writes on each decimated sample strobe: pre-trigger fill,
// arm, wait for trigger, then tp post-trigger samples. Publishes the last
// written address (trace_end) to the dump side.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | RAM port released; waiting for an accepted cap_start
// FILL   | writing pre-trigger samples until DEPTH-tp are in the buffer
// ARMED  | writing circularly, waiting for trig_pulse
// POST   | writing post-trigger samples until tp have been written
// DONE   | single cycle: release RAM port, set cap_done, back to IDLE
`timescale 1ns/1ps
module capture_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_start_i,
  input  logic          smpl_tick_i,
  input  logic          trig_pulse_i,
  input  logic [AW-1:0] trig_pos_i,
  input  logic          dump_busy_i,
  input  logic          clr_done_i,
  output logic          we_o,
  output logic          cap_en_o,
  output logic [AW-1:0] cap_addr_o,
  output logic [AW-1:0] trace_end_o,
  output logic          armed_o,
  output logic          cap_done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] smpl_cnt_q, smpl_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] tp_q, tp_d;
  logic          we_q, we_d;
  logic          cap_en_q, cap_en_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic [AW-1:0] trace_end_q, trace_end_d;
  logic          armed_q, armed_d;
  logic          cap_done_q, cap_done_d;

  logic          start_ok;
  logic          restart;
  logic          active_q;
  logic          wr_fire;
  logic [AW-1:0] fill_tgt;

  // DEPTH is a power of two, so DEPTH - tp fits in AW bits as the two's complement of tp.
  assign fill_tgt = (~tp_q) + ONE;
  assign start_ok = cap_start_i & ~dump_busy_i;
  assign active_q = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
  // A start in DONE is dropped; that cycle only finalises the previous trace.
  assign restart  = start_ok && (state_q != S_DONE);
  // An accepted start owns its cycle: a coincident strobe is not written.
  assign wr_fire  = smpl_tick_i && active_q && !restart;

  // State and registered outputs; async reset aborts everything including trace_end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      smpl_cnt_q  <= '0;
      post_cnt_q  <= '0;
      tp_q        <= ONE;
      we_q        <= 1'b0;
      cap_en_q    <= 1'b0;
      cap_addr_q  <= '0;
      trace_end_q <= '0;
      armed_q     <= 1'b0;
      cap_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      smpl_cnt_q  <= smpl_cnt_d;
      post_cnt_q  <= post_cnt_d;
      tp_q        <= tp_d;
      we_q        <= we_d;
      cap_en_q    <= cap_en_d;
      cap_addr_q  <= cap_addr_d;
      trace_end_q <= trace_end_d;
      armed_q     <= armed_d;
      cap_done_q  <= cap_done_d;
    end
  end

  // Next-state, write pacing and output decode.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    smpl_cnt_d  = smpl_cnt_q;
    post_cnt_d  = post_cnt_q;
    tp_d        = tp_q;
    cap_en_d    = 1'b0;
    cap_addr_d  = cap_addr_q;
    trace_end_d = trace_end_q;
    cap_done_d  = cap_done_q;

    if (clr_done_i) begin
      cap_done_d = 1'b0;
    end

    if (wr_fire) begin
      cap_en_d   = 1'b1;
      cap_addr_d = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + ONE;
    end

    if (restart) begin
      state_d    = S_FILL;
      wr_ptr_d   = '0;
      smpl_cnt_d = '0;
      post_cnt_d = '0;
      tp_d       = (trig_pos_i == '0) ? ONE : trig_pos_i;
      cap_done_d = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (wr_fire) begin
            smpl_cnt_d = smpl_cnt_q + ONE;
            if (smpl_cnt_d == fill_tgt) begin
              state_d = S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (trig_pulse_i) begin
            // A coincident strobe is post sample 1; with tp==1 it completes the trace.
            if (wr_fire && (tp_q == ONE)) begin
              post_cnt_d  = ONE;
              trace_end_d = wr_ptr_q;
              state_d     = S_DONE;
            end else begin
              post_cnt_d = wr_fire ? ONE : '0;
              state_d    = S_POST;
            end
          end
        end
        S_POST: begin
          if (wr_fire) begin
            post_cnt_d = post_cnt_q + ONE;
            if (post_cnt_d == tp_q) begin
              trace_end_d = wr_ptr_q;
              state_d     = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_d    = S_IDLE;
          cap_done_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // The RAM port stays owned through the cycle carrying the final write.
    we_d    = (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST) || cap_en_d;
    armed_d = (state_d == S_ARMED);
  end

  assign we_o        = we_q;
  assign cap_en_o    = cap_en_q;
  assign cap_addr_o  = cap_addr_q;
  assign trace_end_o = trace_end_q;
  assign armed_o     = armed_q;
  assign cap_done_o  = cap_done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed scenarios plus a random
// soak, each checked against a sample-count model of the capture rules.
`timescale 1ns/1ps
module tb_capture_ctrl;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_start = 1'b0;
  logic          smpl_tick = 1'b0;
  logic          trig_pulse = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          dump_busy = 1'b0;
  logic          clr_done = 1'b0;
  logic          we_o, cap_en_o, armed_o, cap_done_o;
  logic [AW-1:0] cap_addr_o, trace_end_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [21:0] obs_q[$];
  logic [21:0] exp_q[$];

  // Model: capture described by how many samples have been written since start.
  int m_phase;   // 0 idle, 1 capturing, 2 final write issued
  int m_writes, m_post, m_tp, m_tend, m_last;
  bit m_trig, m_done;

  capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cap_start_i(cap_start), .smpl_tick_i(smpl_tick), .trig_pulse_i(trig_pulse),
    .trig_pos_i(trig_pos), .dump_busy_i(dump_busy), .clr_done_i(clr_done),
    .we_o(we_o), .cap_en_o(cap_en_o), .cap_addr_o(cap_addr_o),
    .trace_end_o(trace_end_o), .armed_o(armed_o), .cap_done_o(cap_done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void m_reset();
    m_phase = 0; m_writes = 0; m_post = 0; m_tp = 1; m_tend = 0; m_last = 0;
    m_trig = 0; m_done = 0;
  endfunction

  function automatic bit m_armed();
    return (m_phase == 1) && !m_trig && (m_writes >= DEPTH - m_tp);
  endfunction

  function automatic void m_clock(input bit s, t, g, b, c, input int tpv, output bit en);
    en = 0;
    if (c) m_done = 0;
    if (s && !b && m_phase != 2) begin
      m_phase = 1; m_writes = 0; m_trig = 0; m_post = 0; m_done = 0;
      m_tp = (tpv == 0) ? 1 : tpv;
    end else if (m_phase == 1) begin
      if (m_armed() && g) m_trig = 1;
      if (t) begin
        m_last = m_writes % DEPTH;
        m_writes++;
        en = 1;
        if (m_trig) begin
          m_post++;
          if (m_post == m_tp) begin
            m_tend = m_last;
            m_phase = 2;
          end
        end
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
      m_done = 1;
    end
  endfunction

  // Drive one cycle of inputs, advance the model, record DUT and model outputs.
  task automatic step(input bit s, t, g, b, c, input int tpv);
    bit en;
    logic [21:0] e;
    cap_start = s; smpl_tick = t; trig_pulse = g; dump_busy = b; clr_done = c;
    trig_pos = AW'(tpv);
    m_clock(s, t, g, b, c, tpv, en);
    @(posedge clk); #1;
    e = {en, AW'(m_last), m_armed(), (m_phase == 1) || en, m_done, AW'(m_tend)};
    exp_q.push_back(e);
    obs_q.push_back({cap_en_o, cap_addr_o, armed_o, we_o, cap_done_o, trace_end_o});
    cap_start = 0; smpl_tick = 0; trig_pulse = 0; dump_busy = 0; clr_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({we_o, cap_en_o, armed_o, cap_done_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {we_o, cap_en_o, armed_o, cap_done_o});
    end
    n_checks++;
    if (cap_addr_o !== '0) begin n_fail++; $display("FAIL reset_cap_addr: got %0d expected 0", cap_addr_o); end
    n_checks++;
    if (trace_end_o !== '0) begin n_fail++; $display("FAIL reset_trace_end: got %0d expected 0", trace_end_o); end
    @(negedge clk);
    rst_n = 1;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_we: got %b expected 0", we_o); end
  endtask

  int g_ticks;

  task automatic test_fill_timing();
    int pre_en, rise_addr, rise_tick;
    bit seen, rise_en, t;
    obs_q.delete(); exp_q.delete();
    pre_en = 0; seen = 0; rise_addr = -1; rise_tick = -1; rise_en = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, (i % 2) == 1, i == 3, 0, 0, 12);
      pre_en += int'(cap_en_o);
    end
    n_checks++;
    if (pre_en !== 0) begin n_fail++; $display("FAIL fill_no_write_before_start: got %0d writes expected 0", pre_en); end
    step(1, 0, 0, 0, 0, 12);
    g_ticks = 0;
    for (int k = 0; k < 4000 && g_ticks < 500; k++) begin
      t = (k % 4) == 3;
      step(0, t, 0, 0, 0, 12);
      if (t) g_ticks++;
      if (!seen && armed_o) begin
        seen = 1; rise_addr = int'(cap_addr_o); rise_en = cap_en_o; rise_tick = g_ticks;
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL fill_armed_timeout: armed never rose, expected after write 500"); end
    n_checks++;
    if (rise_tick !== 500) begin n_fail++; $display("FAIL fill_armed_write: got write %0d expected 500", rise_tick); end
    n_checks++;
    if (rise_addr !== 499 || rise_en !== 1'b1) begin
      n_fail++; $display("FAIL fill_armed_addr: got addr %0d en %b expected addr 499 en 1", rise_addr, rise_en);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL fill_trace cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_post_count();
    int n_post;
    bit t, g, in_post;
    obs_q.delete(); exp_q.delete();
    n_post = 0; in_post = 0;
    for (int k = 0; k < 1200 && !cap_done_o; k++) begin
      t = (k % 4) == 3;
      g = t && (g_ticks + 1 == 700);
      step(0, t, g, 0, 0, 12);
      if (t) g_ticks++;
      if (g) in_post = 1;
      if (in_post && cap_en_o) n_post++;
    end
    n_checks++;
    if (cap_done_o !== 1'b1) begin n_fail++; $display("FAIL post_done: got %b expected 1", cap_done_o); end
    n_checks++;
    if (n_post !== 12) begin n_fail++; $display("FAIL post_writes: got %0d expected 12", n_post); end
    n_checks++;
    if (trace_end_o !== 9'd198) begin n_fail++; $display("FAIL post_trace_end: got %0d expected 198", trace_end_o); end
    n_checks++;
    if (we_o !== 1'b0) begin n_fail++; $display("FAIL post_we_released: got %b expected 0", we_o); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL post_trace cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_early_trigger();
    int ticks, rise_addr, rise_tick, exp_end;
    bit seen, fired, t, g;
    obs_q.delete(); exp_q.delete();
    step(0, 0, 0, 0, 1, 12);
    n_checks++;
    if (cap_done_o !== 1'b0) begin n_fail++; $display("FAIL early_clr_done: got %b expected 0", cap_done_o); end
    step(1, 0, 0, 0, 0, 12);
    ticks = 0; seen = 0; fired = 0; rise_addr = -1; rise_tick = -1; exp_end = -1;
    for (int k = 0; k < 4000 && !cap_done_o; k++) begin
      t = $urandom_range(0, 2) != 0;
      if (ticks < 500) g = ($urandom_range(0, 5) == 0) || (ticks == 100);
      else if (fired) g = $urandom_range(0, 3) == 0;
      else g = (ticks >= 540) || ((ticks >= 505) && ($urandom_range(0, 2) == 0));
      if (g && !fired && ticks >= 500) begin
        fired = 1;
        exp_end = (ticks + 11) % DEPTH;
      end
      step(0, t, g, 0, 0, 12);
      if (t) ticks++;
      if (!seen && armed_o) begin seen = 1; rise_addr = int'(cap_addr_o); rise_tick = ticks; end
    end
    n_checks++;
    if (rise_tick !== 500 || rise_addr !== 499) begin
      n_fail++; $display("FAIL early_armed: got write %0d addr %0d expected write 500 addr 499", rise_tick, rise_addr);
    end
    n_checks++;
    if (cap_done_o !== 1'b1) begin n_fail++; $display("FAIL early_done: got %b expected 1", cap_done_o); end
    n_checks++;
    if (int'(trace_end_o) !== exp_end) begin
      n_fail++; $display("FAIL early_trace_end: got %0d expected %0d", trace_end_o, exp_end);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL early_trace cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clamping();
    int ticks, rise_addr, rise_tick;
    bit seen;
    obs_q.delete(); exp_q.delete();
    // trig_pos=0 behaves as 1: 511 pre-trigger writes, one post sample.
    step(1, 0, 0, 0, 0, 0);
    ticks = 0; seen = 0; rise_addr = -1; rise_tick = -1;
    for (int k = 0; k < 700 && ticks < 511; k++) begin
      step(0, 1, 0, 0, 0, 0);
      ticks++;
      if (!seen && armed_o) begin seen = 1; rise_addr = int'(cap_addr_o); rise_tick = ticks; end
    end
    n_checks++;
    if (rise_tick !== 511 || rise_addr !== 510) begin
      n_fail++; $display("FAIL clamp0_armed: got write %0d addr %0d expected write 511 addr 510", rise_tick, rise_addr);
    end
    step(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 10 && !cap_done_o; k++) step(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (cap_done_o !== 1'b1 || trace_end_o !== 9'd511) begin
      n_fail++; $display("FAIL clamp0_trace_end: got done %b end %0d expected done 1 end 511", cap_done_o, trace_end_o);
    end
    // trig_pos=511: armed after the very first write.
    step(1, 0, 0, 0, 0, 511);
    step(0, 1, 0, 0, 0, 511);
    n_checks++;
    if (armed_o !== 1'b1 || cap_addr_o !== 9'd0 || cap_en_o !== 1'b1) begin
      n_fail++; $display("FAIL clamp511_armed: got armed %b en %b addr %0d expected armed 1 en 1 addr 0",
                         armed_o, cap_en_o, cap_addr_o);
    end
    repeat (3) step(0, 1, 0, 0, 0, 511);
    step(0, 0, 1, 0, 0, 511);
    for (int k = 0; k < 700 && !cap_done_o; k++) step(0, 1, 0, 0, 0, 511);
    n_checks++;
    if (cap_done_o !== 1'b1 || trace_end_o !== 9'd2) begin
      n_fail++; $display("FAIL clamp511_trace_end: got done %b end %0d expected done 1 end 2", cap_done_o, trace_end_o);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL clamp_trace cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_restart();
    int n_en, ticks;
    obs_q.delete(); exp_q.delete();
    n_en = 0;
    step(1, 0, 0, 1, 0, 100);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 1, 0, 100);
      n_en += int'(cap_en_o);
    end
    n_checks++;
    if (we_o !== 1'b0 || n_en !== 0) begin
      n_fail++; $display("FAIL busy_ignored: got we %b writes %0d expected we 0 writes 0", we_o, n_en);
    end
    n_checks++;
    if (cap_done_o !== 1'b1) begin n_fail++; $display("FAIL busy_done_kept: got %b expected 1", cap_done_o); end
    step(1, 0, 0, 0, 0, 300);
    ticks = 0;
    for (int k = 0; k < 400 && ticks < 212; k++) begin
      step(0, 1, 0, 0, 0, 300);
      ticks++;
    end
    n_checks++;
    if (armed_o !== 1'b1) begin n_fail++; $display("FAIL busy_armed: got %b expected 1", armed_o); end
    step(0, 1, 1, 0, 0, 300);
    repeat (2) step(0, 1, 0, 0, 0, 300);
    step(1, 0, 0, 0, 0, 300);
    step(0, 1, 0, 0, 0, 300);
    n_checks++;
    if (cap_en_o !== 1'b1 || cap_addr_o !== 9'd0 || we_o !== 1'b1 || armed_o !== 1'b0) begin
      n_fail++; $display("FAIL restart_addr: got en %b addr %0d we %b armed %b expected en 1 addr 0 we 1 armed 0",
                         cap_en_o, cap_addr_o, we_o, armed_o);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL busy_trace cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_post_and_clr();
    int ticks;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 400 && !armed_o; k++) step(0, 1, 0, 0, 0, 300);
    step(0, 1, 1, 0, 0, 300);
    repeat (3) step(0, 1, 0, 0, 0, 300);
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({we_o, cap_en_o, cap_addr_o, trace_end_o, armed_o, cap_done_o} !== '0) begin
      n_fail++; $display("FAIL rst_post_async: got we %b en %b addr %0d end %0d armed %b done %b expected all 0",
                         we_o, cap_en_o, cap_addr_o, trace_end_o, armed_o, cap_done_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({we_o, cap_en_o, cap_addr_o, trace_end_o, armed_o, cap_done_o} !== '0) begin
      n_fail++; $display("FAIL rst_post_edge: got we %b en %b addr %0d end %0d armed %b done %b expected all 0",
                         we_o, cap_en_o, cap_addr_o, trace_end_o, armed_o, cap_done_o);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1;
    // Complete a trace and pulse clr_done in the cycle that sets cap_done.
    step(1, 0, 0, 0, 0, 1);
    ticks = 0;
    for (int k = 0; k < 700 && m_phase != 2; k++) begin
      step(0, 1, ticks >= 511, 0, 0, 1);
      ticks++;
    end
    step(0, 0, 0, 0, 1, 1);
    n_checks++;
    if (cap_done_o !== 1'b1) begin n_fail++; $display("FAIL clr_set_collide: got %b expected 1", cap_done_o); end
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (trace_end_o !== 9'd511) begin n_fail++; $display("FAIL clr_set_trace_end: got %0d expected 511", trace_end_o); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstclr_trace cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit s, t, g, b, c;
    int tpv, sel;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 9000; k++) begin
      s = ($urandom_range(0, 699) == 0) || ((m_phase == 0) && ($urandom_range(0, 19) == 0));
      t = $urandom_range(0, 2) != 0;
      g = $urandom_range(0, 39) == 0;
      b = $urandom_range(0, 3) == 0;
      c = $urandom_range(0, 63) == 0;
      sel = int'($urandom_range(0, 7));
      tpv = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 511 : int'($urandom_range(0, 511));
      step(s, t, g, b, c, tpv);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random_trace cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_timing();
    test_post_count();
    test_early_trigger();
    test_clamping();
    test_busy_restart();
    test_reset_post_and_clr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
